// File: rtl/mdc_tcdm_port_arbiter.sv
// mdc_tcdm_port_arbiter
// Shares a single TCDM master port among N_REQ requester ports with round-robin
// arbitration, and routes responses back to the requester that was granted, in
// grant order.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   in_req/in_gnt       requester handshake (per port)
//   in_add/in_wen/in_be/in_data   requester transaction fields (per port)
//   in_r_data/in_r_valid          response to requesters (data broadcast)
//   out_req/out_gnt     master handshake
//   out_add/out_wen/out_be/out_data  master transaction fields (muxed)
//   out_r_data/out_r_valid           master response
//   busy_o              some granted request is still awaiting its response
//   err_o               sticky: a response arrived with nothing outstanding
module mdc_tcdm_port_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_REQ-1:0]              in_req,
  output logic [N_REQ-1:0]              in_gnt,
  input  logic [N_REQ-1:0][AW-1:0]      in_add,
  input  logic [N_REQ-1:0]              in_wen,
  input  logic [N_REQ-1:0][DW/8-1:0]    in_be,
  input  logic [N_REQ-1:0][DW-1:0]      in_data,
  output logic [N_REQ-1:0][DW-1:0]      in_r_data,
  output logic [N_REQ-1:0]              in_r_valid,
  output logic                          out_req,
  input  logic                          out_gnt,
  output logic [AW-1:0]                 out_add,
  output logic                          out_wen,
  output logic [DW/8-1:0]               out_be,
  output logic [DW-1:0]                 out_data,
  input  logic [DW-1:0]                 out_r_data,
  input  logic                          out_r_valid,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  idx_t rr_ptr_q, rr_ptr_d;
  logic lock_q, lock_d;
  idx_t lock_sel_q, lock_sel_d;
  idx_t fifo_q [DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic err_q, err_d;
  logic busy_q;

  idx_t rr_sel, cand, sel;
  logic rr_found, lock_hold, any_req, push, pop;

  // Pointers wrap explicitly so non-power-of-two depths also behave.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic idx_t idx_inc(input idx_t i);
    return (i == idx_t'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // Round-robin scan: first asserted request at or after rr_ptr.
  always_comb begin
    rr_sel   = rr_ptr_q;
    rr_found = 1'b0;
    cand     = rr_ptr_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!rr_found && in_req[cand]) begin
        rr_found = 1'b1;
        rr_sel   = cand;
      end
      cand = idx_inc(cand);
    end
  end

  // A requester left waiting keeps the port until granted or it withdraws.
  assign lock_hold = lock_q && in_req[lock_sel_q];
  assign sel       = lock_hold ? lock_sel_q : rr_sel;
  assign any_req   = |in_req;

  // Full blocks requests even when a response frees a slot this cycle.
  assign out_req = any_req && (count_q < cnt_t'(DEPTH));
  assign push    = out_req && out_gnt;
  assign pop     = out_r_valid && (count_q != '0);

  always_comb begin
    out_add  = '0;
    out_wen  = 1'b0;
    out_be   = '0;
    out_data = '0;
    if (any_req) begin
      out_add  = in_add[sel];
      out_wen  = in_wen[sel];
      out_be   = in_be[sel];
      out_data = in_data[sel];
    end
  end

  always_comb begin
    in_gnt     = '0;
    in_r_valid = '0;
    if (push) in_gnt[sel] = 1'b1;
    if (pop)  in_r_valid[fifo_q[rd_ptr_q]] = 1'b1;
    for (int unsigned i = 0; i < N_REQ; i++) in_r_data[i] = out_r_data;
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_hold;
    lock_sel_d = lock_sel_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    err_d      = err_q | (out_r_valid && (count_q == '0));

    if (push) begin
      rr_ptr_d = idx_inc(sel);
      wr_ptr_d = ptr_inc(wr_ptr_q);
      lock_d   = 1'b0;
    end else if (out_req) begin
      lock_d     = 1'b1;
      lock_sel_d = sel;
    end

    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      busy_q     <= (count_d != '0);
    end
  end

  // Index storage needs no reset: entries are only read behind count.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= sel;
  end

  assign busy_o = busy_q;
  assign err_o  = err_q;

endmodule
